// File: rtl/piano_note_player_if.sv
// Key byte stream between a byte source (e.g. UART RX FIFO) and the note player.
`timescale 1ns/1ps
interface piano_note_player_if;
    logic [7:0] key_data;
    logic       key_valid;
    logic       key_ready;

    modport master (output key_data, output key_valid, input key_ready);
    modport slave  (input key_data, input key_valid, output key_ready);
endinterface

// File: rtl/piano_note_player.sv
// Reads a tone period from the key-to-tone table for each key byte, then plays it
// for NOTE_CYCLES followed by GAP_CYCLES of silence; unmapped keys are counted.
`timescale 1ns/1ps
module piano_note_player #(
    parameter int NOTE_CYCLES = 25000000,
    parameter int GAP_CYCLES  = 1250000,
    parameter int CNT_WIDTH   = 25
) (
    input  logic                 clk,
    input  logic                 rst_n,
    piano_note_player_if.slave   key,
    output logic [7:0]           rom_address,
    input  logic [23:0]          rom_data,
    output logic [23:0]          tone_period,
    output logic                 note_active,
    input  logic                 stop,
    output logic [7:0]           drop_count
);

    typedef enum logic [1:0] {IDLE, LOOKUP, PLAY, GAP} state_t;

    localparam logic [CNT_WIDTH-1:0] NOTE_LOAD = CNT_WIDTH'(NOTE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] GAP_LOAD  =
        (GAP_CYCLES > 0) ? CNT_WIDTH'(GAP_CYCLES - 1) : '0;

    state_t               state, state_d;
    logic [CNT_WIDTH-1:0] cnt, cnt_d;
    logic [7:0]           rom_address_d;
    logic [23:0]          tone_d;
    logic                 active_d;
    logic [7:0]           drop_d;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        state_d       = state;
        cnt_d         = cnt;
        rom_address_d = rom_address;
        tone_d        = tone_period;
        active_d      = note_active;
        drop_d        = drop_count;

        case (state)
            IDLE: begin
                // stop masks acceptance even though key_ready is still high
                if (!stop && key.key_valid && key.key_ready) begin
                    rom_address_d = key.key_data;
                    state_d       = LOOKUP;
                end
            end
            LOOKUP: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (rom_data == 24'd0) begin
                    if (drop_count != 8'hFF) drop_d = drop_count + 8'd1;
                    state_d = IDLE;
                end else begin
                    tone_d   = rom_data;
                    active_d = 1'b1;
                    cnt_d    = NOTE_LOAD;
                    state_d  = PLAY;
                end
            end
            PLAY: begin
                if (stop || cnt == '0) begin
                    tone_d   = 24'd0;
                    active_d = 1'b0;
                    if (!stop && GAP_CYCLES > 0) begin
                        cnt_d   = GAP_LOAD;
                        state_d = GAP;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt - 1'b1;
                end
            end
            GAP: begin
                if (stop || cnt == '0) state_d = IDLE;
                else                   cnt_d   = cnt - 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            rom_address   <= 8'd0;
            tone_period   <= 24'd0;
            note_active   <= 1'b0;
            drop_count    <= 8'd0;
            key.key_ready <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state         <= state_d;
            cnt           <= cnt_d;
            rom_address   <= rom_address_d;
            tone_period   <= tone_d;
            note_active   <= active_d;
            drop_count    <= drop_d;
            key.key_ready <= (state_d == IDLE);
        end
    end

endmodule

// File: tb/tb_piano_note_player.sv
// Directed bench for piano_note_player: scoreboard of expected notes plus direct
// checks of handshake timing, drop counting, stop and reset behaviour.
`timescale 1ns/1ps
module tb_piano_note_player;

    logic        clk;
    logic        rst_n;
    logic        stop0, stop1;
    logic [7:0]  rom_address0, rom_address1, drop_count0, drop_count1;
    logic [23:0] rom_data0, rom_data1, tone0, tone1;
    logic        active0, active1;
    int          cyc = 0;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        int period;
        int len;
        int gap;   // silent samples before the note, -1 = don't care
    } exp_t;
    exp_t sb[$];

    piano_note_player_if kif0();
    piano_note_player_if kif1();

    piano_note_player #(.NOTE_CYCLES(8), .GAP_CYCLES(2), .CNT_WIDTH(4)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .key(kif0.slave),
        .rom_address(rom_address0), .rom_data(rom_data0),
        .tone_period(tone0), .note_active(active0),
        .stop(stop0), .drop_count(drop_count0)
    );

    piano_note_player #(.NOTE_CYCLES(1), .GAP_CYCLES(0), .CNT_WIDTH(4)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .key(kif1.slave),
        .rom_address(rom_address1), .rom_data(rom_data1),
        .tone_period(tone1), .note_active(active1),
        .stop(stop1), .drop_count(drop_count1)
    );

    function automatic logic [23:0] rom_fn(input logic [7:0] a);
        case (a)
            8'd122:  rom_fn = 24'd477781;  // 'z'
            8'd113:  rom_fn = 24'd238891;  // 'q'
            8'd90:   rom_fn = 24'd955564;  // 'Z'
            8'd101:  rom_fn = 24'd189608;  // 'e'
            default: rom_fn = 24'd0;
        endcase
    endfunction

    assign rom_data0 = rom_fn(rom_address0);
    assign rom_data1 = rom_fn(rom_address1);

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard monitor for DUT0: measures every note and its leading silence.
    bit in_note = 0;
    int cur_p = 0, cur_len = 0, silent = 0, gap_seen = 0;
    always @(negedge clk) begin
        exp_t e;
        check("note_active_vs_tone", 32'(active0), 32'(tone0 != 24'd0));
        if (tone0 != 24'd0) begin
            if (!in_note) begin
                in_note  = 1;
                cur_p    = int'(tone0);
                cur_len  = 0;
                gap_seen = silent;
            end else if (int'(tone0) != cur_p) begin
                check("tone_stable", 32'(tone0), 32'(cur_p));
            end
            cur_len++;
            silent = 0;
        end else begin
            if (in_note) begin
                in_note = 0;
                if (sb.size() == 0) begin
                    check("unexpected_note", 32'(cur_p), 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("note_period", 32'(cur_p), 32'(e.period));
                    check("note_length", 32'(cur_len), 32'(e.len));
                    if (e.gap >= 0) check("note_gap", 32'(gap_seen), 32'(e.gap));
                end
            end
            silent++;
        end
    end

    function automatic logic rdy(input int sel);
        return (sel == 0) ? kif0.key_ready : kif1.key_ready;
    endfunction

    // Offers a byte and returns at the negedge after the accepting edge, with
    // acc = cycle number of that edge. hold keeps key_valid high afterwards.
    task automatic send_key(input int sel, input logic [7:0] k, input bit hold, output int acc);
        int waited = 0;
        acc = -1;
        @(negedge clk);
        if (sel == 0) begin kif0.key_data = k; kif0.key_valid = 1'b1; end
        else          begin kif1.key_data = k; kif1.key_valid = 1'b1; end
        while (!rdy(sel) && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!rdy(sel)) begin
            check("accept_timeout", 32'd0, 32'd1);
        end else begin
            @(negedge clk);
            acc = cyc;
        end
        if (!hold) begin
            if (sel == 0) kif0.key_valid = 1'b0;
            else          kif1.key_valid = 1'b0;
        end
    endtask

    initial begin
        int n, n2, waited;
        exp_t e;
        rst_n = 1'b0;
        stop0 = 1'b0; stop1 = 1'b0;
        kif0.key_data = 8'd0; kif0.key_valid = 1'b0;
        kif1.key_data = 8'd0; kif1.key_valid = 1'b0;

        // Reset state
        #12;
        check("rst_tone", 32'(tone0), 32'd0);
        check("rst_active", 32'(active0), 32'd0);
        check("rst_ready", 32'(kif0.key_ready), 32'd0);
        check("rst_rom_address", 32'(rom_address0), 32'd0);
        check("rst_drop", 32'(drop_count0), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("ready_before_first_edge", 32'(kif0.key_ready), 32'd0);
        @(posedge clk);
        #1 check("ready_after_release", 32'(kif0.key_ready), 32'd1);

        // 'z': latency, 8-cycle note, 2-cycle gap, ready back 11 edges after accept
        e = '{477781, 8, -1}; sb.push_back(e);
        send_key(0, 8'd122, 0, n);
        check("z_rom_address", 32'(rom_address0), 32'd122);
        check("z_lookup_silent", 32'(tone0), 32'd0);
        @(negedge clk);
        check("z_tone_after_lookup", 32'(tone0), 32'd477781);
        waited = 0;
        while (!kif0.key_ready && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        check("z_ready_edge", 32'(cyc - n), 32'd11);

        // 'A' unmapped: dropped in 2 cycles
        send_key(0, 8'd65, 0, n);
        check("A_lookup_drop", 32'(drop_count0), 32'd0);
        @(negedge clk);
        check("A_drop", 32'(drop_count0), 32'd1);
        check("A_ready_back", 32'(kif0.key_ready), 32'd1);

        // stop during LOOKUP: no drop count and no note
        send_key(0, 8'd65, 0, n);
        stop0 = 1'b1;
        @(negedge clk);
        stop0 = 1'b0;
        check("stop_lookup_drop", 32'(drop_count0), 32'd1);
        check("stop_lookup_ready", 32'(kif0.key_ready), 32'd1);
        send_key(0, 8'd122, 0, n);
        stop0 = 1'b1;
        @(negedge clk);
        stop0 = 1'b0;
        repeat (3) @(negedge clk);

        // stop in IDLE with a pending key: byte not consumed
        stop0 = 1'b1;
        kif0.key_data = 8'd65; kif0.key_valid = 1'b1;
        @(negedge clk);
        stop0 = 1'b0; kif0.key_valid = 1'b0;
        check("stop_idle_rom_address", 32'(rom_address0), 32'd122);
        check("stop_idle_ready", 32'(kif0.key_ready), 32'd1);

        // Reset held low mid-PLAY
        e = '{477781, 3, -1}; sb.push_back(e);
        send_key(0, 8'd122, 0, n);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_tone", 32'(tone0), 32'd0);
        check("midrst_active", 32'(active0), 32'd0);
        check("midrst_drop", 32'(drop_count0), 32'd0);
        check("midrst_ready", 32'(kif0.key_ready), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1 check("midrst_ready_release", 32'(kif0.key_ready), 32'd1);

        // Back-to-back 'q' then 'Z' with key_valid held high
        e = '{238891, 8, -1}; sb.push_back(e);
        e = '{955564, 8, 4};  sb.push_back(e);
        send_key(0, 8'd113, 1, n);
        kif0.key_data = 8'd90;
        send_key(0, 8'd90, 0, n2);
        check("b2b_spacing", 32'(n2 - n), 32'd12);
        check("b2b_rom_address", 32'(rom_address0), 32'd90);
        waited = 0;
        while (!kif0.key_ready && waited < 40) begin
            @(negedge clk);
            waited++;
        end

        // stop on the 3rd PLAY cycle of 'q', then a full 'e'
        e = '{238891, 3, -1}; sb.push_back(e);
        send_key(0, 8'd113, 0, n);
        repeat (3) @(negedge clk);
        stop0 = 1'b1;
        @(negedge clk);
        stop0 = 1'b0;
        check("stop_play_tone", 32'(tone0), 32'd0);
        check("stop_play_active", 32'(active0), 32'd0);
        check("stop_play_ready", 32'(kif0.key_ready), 32'd1);
        e = '{189608, 8, -1}; sb.push_back(e);
        send_key(0, 8'd101, 0, n);
        waited = 0;
        while (!kif0.key_ready && waited < 40) begin
            @(negedge clk);
            waited++;
        end

        // 300 unmapped keys: saturation at 255
        for (int i = 0; i < 300; i++) begin
            send_key(0, 8'(8'd65 + 8'(i % 5)), 0, n);
            @(negedge clk);
            if (i == 253) check("drop_254", 32'(drop_count0), 32'd254);
            if (i == 254) check("drop_255", 32'(drop_count0), 32'd255);
        end
        check("drop_saturated", 32'(drop_count0), 32'd255);

        // NOTE_CYCLES=1, GAP_CYCLES=0: one-cycle tone, straight back to IDLE
        send_key(1, 8'd101, 0, n);
        check("e1_rom_address", 32'(rom_address1), 32'd101);
        check("e1_lookup_silent", 32'(tone1), 32'd0);
        @(negedge clk);
        check("e1_tone", 32'(tone1), 32'd189608);
        check("e1_active", 32'(active1), 32'd1);
        @(negedge clk);
        check("e1_tone_off", 32'(tone1), 32'd0);
        check("e1_active_off", 32'(active1), 32'd0);
        check("e1_ready", 32'(kif1.key_ready), 32'd1);

        // Drain the scoreboard
        waited = 0;
        while ((sb.size() != 0 || in_note) && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        check("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
